tile_step_scheduler: RTL and testbench

Sequences one matmul layer's tile steps across the IA loader and the weight loader. Both loaders share one ICB master port, so their load requests are serialized through a 2-way round-robin grant. Once both loaders report valid tile data, the block fires simultaneous send triggers into the systolic array and waits until both loaders finish sending. It counts completed steps and signals layer completion to the top-level controller.

---
 rtl/dsa_sched_pkg.sv | 24 ++
 rtl/ld_rr_arb2.sv | 43 ++++
 rtl/tile_step_scheduler.sv | 151 +++++++++++++++
 tb/tb_tile_step_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsa_sched_pkg.sv
// Shared types for the tile step scheduler: FSM encodings and requester indices.
package dsa_sched_pkg;

  typedef enum logic {
    TOP_IDLE = 1'b0,
    TOP_RUN  = 1'b1
  } sched_top_t;

  typedef enum logic [1:0] {
    ARB_FREE   = 2'd0,
    ARB_OWN_IA = 2'd1,
    ARB_OWN_W  = 2'd2
  } arb_state_t;

  typedef enum logic {
    SEND_WAIT = 1'b0,
    SEND_SEND = 1'b1
  } send_state_t;

  // Bit positions in the request/grant vectors.
  localparam logic REQ_IA = 1'b0;
  localparam logic REQ_W  = 1'b1;

endpackage

// File: rtl/ld_rr_arb2.sv
// Two-requester round-robin arbiter with a registered one-hot grant.
// The priority pointer only moves on contested cycles: an uncontested grant
// does not change who wins the next tie.
module ld_rr_arb2
  import dsa_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt_nxt,
  output logic [1:0] gnt
);

  // High when the weight loader wins the next tie; reset gives IA priority.
  logic w_prio;

  // Pick the winner for this cycle; nothing is granted while disabled.
  always_comb begin
    gnt_nxt = 2'b00;
    if (en) begin
      if (req[REQ_IA] && req[REQ_W]) begin
        if (w_prio) gnt_nxt[REQ_W]  = 1'b1;
        else        gnt_nxt[REQ_IA] = 1'b1;
      end else begin
        gnt_nxt = req;
      end
    end
  end

  // Register the grant pulse and flip priority away from a tie winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt    <= 2'b00;
      w_prio <= 1'b0;
    end else begin
      gnt <= gnt_nxt;
      if (en && req[REQ_IA] && req[REQ_W])
        w_prio <= gnt_nxt[REQ_IA];
    end
  end

endmodule

// File: rtl/tile_step_scheduler.sv
// Sequences a layer's tile steps: serializes IA/weight loads on the shared
// ICB port, fires paired send triggers once both tiles are buffered, and
// counts completed steps until the latched total is reached.
module tile_step_scheduler
  import dsa_sched_pkg::*;
#(
  parameter int REG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [REG_WIDTH-1:0] total_steps,
  input  logic                 ia_load_req,
  output logic                 ia_load_granted,
  input  logic                 w_load_req,
  output logic                 w_load_granted,
  input  logic                 ia_data_valid,
  input  logic                 w_data_valid,
  output logic                 ia_send_trigger,
  output logic                 w_send_trigger,
  input  logic                 ia_sending_done,
  input  logic                 w_sending_done,
  output logic                 busy,
  output logic                 done,
  output logic [REG_WIDTH-1:0] step_count
);

  sched_top_t  top_q, top_d;
  arb_state_t  arb_q, arb_d;
  send_state_t snd_q, snd_d;

  logic [REG_WIDTH-1:0] tot_q, step_q, step_inc;
  logic                 ia_flag_q, w_flag_q;
  logic                 trig_q, done_q;
  logic                 run_go, arb_en, both_done, last_step, fire, done_d;
  logic [1:0]           gnt_nxt, gnt;

  // Qualifiers shared by all three FSMs. A zero-step layer spends its single
  // RUN cycle doing nothing, so arbitration and sending stay disabled.
  always_comb begin
    run_go    = (top_q == TOP_RUN) && (tot_q != '0);
    arb_en    = run_go && (arb_q == ARB_FREE);
    step_inc  = step_q + 1'b1;
    both_done = (ia_flag_q | ia_sending_done) & (w_flag_q | w_sending_done);
    last_step = (snd_q == SEND_SEND) && both_done && (step_inc == tot_q);
  end

  ld_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (arb_en),
    .req     ({w_load_req, ia_load_req}),
    .gnt_nxt (gnt_nxt),
    .gnt     (gnt)
  );

  // State registers for the top, arbiter-ownership and send FSMs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q <= TOP_IDLE;
      arb_q <= ARB_FREE;
      snd_q <= SEND_WAIT;
    end else begin
      top_q <= top_d;
      arb_q <= arb_d;
      snd_q <= snd_d;
    end
  end

  // Top FSM: start launches a layer, last step (or an empty layer) ends it.
  always_comb begin
    top_d = top_q;
    case (top_q)
      TOP_IDLE: if (start) top_d = TOP_RUN;
      TOP_RUN:  if ((tot_q == '0) || last_step) top_d = TOP_IDLE;
      default:  top_d = TOP_IDLE;
    endcase
  end

  // Ownership FSM: the granted loader holds the port until its tile is buffered.
  always_comb begin
    arb_d = arb_q;
    case (arb_q)
      ARB_FREE: begin
        if (gnt_nxt[REQ_IA])     arb_d = ARB_OWN_IA;
        else if (gnt_nxt[REQ_W]) arb_d = ARB_OWN_W;
      end
      ARB_OWN_IA: if (ia_data_valid) arb_d = ARB_FREE;
      ARB_OWN_W:  if (w_data_valid)  arb_d = ARB_FREE;
      default:    arb_d = ARB_FREE;
    endcase
    if (!run_go) arb_d = ARB_FREE;
  end

  // Send FSM: trigger once both tiles are ready and the port is idle,
  // then wait for both streams to finish.
  always_comb begin
    snd_d = snd_q;
    case (snd_q)
      SEND_WAIT: if (run_go && ia_data_valid && w_data_valid && (arb_q == ARB_FREE))
                   snd_d = SEND_SEND;
      SEND_SEND: if (both_done) snd_d = SEND_WAIT;
      default:   snd_d = SEND_WAIT;
    endcase
    if (!run_go) snd_d = SEND_WAIT;
  end

  // Output decode: pulses are computed here and registered below.
  always_comb begin
    busy   = (top_q == TOP_RUN);
    fire   = (snd_q == SEND_WAIT) && (snd_d == SEND_SEND);
    done_d = ((top_q == TOP_IDLE) && start && (total_steps == '0)) || last_step;
  end

  // Layer bookkeeping, sticky sending_done flags and registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tot_q     <= '0;
      step_q    <= '0;
      ia_flag_q <= 1'b0;
      w_flag_q  <= 1'b0;
      trig_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      trig_q <= fire;
      done_q <= done_d;
      if ((top_q == TOP_IDLE) && start) begin
        tot_q  <= total_steps;
        step_q <= '0;
      end
      if (snd_q == SEND_SEND) begin
        if (both_done) begin
          ia_flag_q <= 1'b0;
          w_flag_q  <= 1'b0;
          step_q    <= step_inc;
        end else begin
          ia_flag_q <= ia_flag_q | ia_sending_done;
          w_flag_q  <= w_flag_q  | w_sending_done;
        end
      end
    end
  end

  assign ia_load_granted = gnt[REQ_IA];
  assign w_load_granted  = gnt[REQ_W];
  assign ia_send_trigger = trig_q;
  assign w_send_trigger  = trig_q;
  assign done            = done_q;
  assign step_count      = step_q;

endmodule

// File: tb/tb_tile_step_scheduler.sv
// Directed bench for tile_step_scheduler: fixed cycle-accurate scenarios with
// hand-derived expectations, checked by immediate assertions.
module tb_tile_step_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] total_steps;
  logic        ia_load_req, w_load_req;
  logic        ia_load_granted, w_load_granted;
  logic        ia_data_valid, w_data_valid;
  logic        ia_send_trigger, w_send_trigger;
  logic        ia_sending_done, w_sending_done;
  logic        busy, done;
  logic [31:0] step_count;

  tile_step_scheduler #(.REG_WIDTH(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .total_steps     (total_steps),
    .ia_load_req     (ia_load_req),
    .ia_load_granted (ia_load_granted),
    .w_load_req      (w_load_req),
    .w_load_granted  (w_load_granted),
    .ia_data_valid   (ia_data_valid),
    .w_data_valid    (w_data_valid),
    .ia_send_trigger (ia_send_trigger),
    .w_send_trigger  (w_send_trigger),
    .ia_sending_done (ia_sending_done),
    .w_sending_done  (w_sending_done),
    .busy            (busy),
    .done            (done),
    .step_count      (step_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Event counters sampled mid-cycle; scenarios compare deltas.
  int n_ia_gnt = 0, n_w_gnt = 0, n_ia_trig = 0, n_w_trig = 0, n_done = 0, n_both = 0;
  always @(negedge clk) begin
    if (ia_load_granted) n_ia_gnt++;
    if (w_load_granted)  n_w_gnt++;
    if (ia_load_granted && w_load_granted) n_both++;
    if (ia_send_trigger) n_ia_trig++;
    if (w_send_trigger)  n_w_trig++;
    if (done) n_done++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Returns 0 for an IA grant, 1 for a weight grant, -1 on timeout.
  task automatic wait_gnt(output int g);
    g = -1;
    for (int i = 0; i < 20 && g < 0; i++) begin
      tick();
      if (ia_load_granted)     g = 0;
      else if (w_load_granted) g = 1;
    end
  endtask

  task automatic wait_trig(output int ok);
    ok = 0;
    for (int i = 0; i < 20 && ok == 0; i++) begin
      tick();
      if (ia_send_trigger) ok = 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, ok;
    int s_trig, s_wtrig, s_done, s_both, s_igt, s_wgt;
    int exp_ord [6] = '{0, 1, 1, 0, 0, 1};

    rst_n = 1'b0; start = 0; total_steps = 0;
    ia_load_req = 0; w_load_req = 0; ia_data_valid = 0; w_data_valid = 0;
    ia_sending_done = 0; w_sending_done = 0;
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step", step_count, 0);
    chk("rst_ia_gnt", ia_load_granted, 0);
    chk("rst_w_gnt", w_load_granted, 0);
    chk("rst_ia_trig", ia_send_trigger, 0);
    chk("rst_w_trig", w_send_trigger, 0);
    rst_n = 1'b1;
    tick();

    // Single step with staggered requests.
    s_trig = n_ia_trig; s_wtrig = n_w_trig;
    start = 1; total_steps = 1; tick();            // c1
    start = 0;
    chk("t1_busy", busy, 1);
    chk("t1_step0", step_count, 0);
    ia_load_req = 1; tick();                       // c2
    chk("t1_ia_gnt", ia_load_granted, 1);
    chk("t1_w_gnt_idle", w_load_granted, 0);
    ia_load_req = 0; tick();                       // c3
    chk("t1_ia_gnt_pulse", ia_load_granted, 0);
    w_load_req = 1; repeat (4) tick();             // c7
    chk("t1_w_blocked", w_load_granted, 0);
    ia_data_valid = 1; tick();                     // c8
    chk("t1_w_not_yet", w_load_granted, 0);
    tick();                                        // c9
    chk("t1_w_gnt", w_load_granted, 1);
    w_load_req = 0; repeat (5) tick();             // c14
    w_data_valid = 1; tick();                      // c15
    chk("t1_trig_early", ia_send_trigger, 0);
    tick();                                        // c16
    chk("t1_ia_trig", ia_send_trigger, 1);
    chk("t1_w_trig", w_send_trigger, 1);
    repeat (16) tick();                            // c32
    chk("t1_done_early", done, 0);
    chk("t1_trig_cnt", n_ia_trig - s_trig, 1);
    chk("t1_wtrig_cnt", n_w_trig - s_wtrig, 1);
    ia_sending_done = 1; w_sending_done = 1; tick(); // c33
    ia_sending_done = 0; w_sending_done = 0;
    chk("t1_done", done, 1);
    chk("t1_step", step_count, 1);
    chk("t1_busy_fall", busy, 0);
    tick();
    chk("t1_done_pulse", done, 0);
    ia_data_valid = 0; w_data_valid = 0;

    // Simultaneous requests, three rounds.
    start = 1; total_steps = 3; tick();
    start = 0;
    s_done = n_done; s_trig = n_ia_trig; s_both = n_both;
    for (int r = 0; r < 3; r++) begin
      ia_load_req = 1; w_load_req = 1; ia_data_valid = 0; w_data_valid = 0;
      for (int k = 0; k < 2; k++) begin
        wait_gnt(g);
        chk($sformatf("t2_order%0d", r * 2 + k), g, exp_ord[r * 2 + k]);
        if (g == 0) begin ia_load_req = 0; ia_data_valid = 1; end
        else if (g == 1) begin w_load_req = 0; w_data_valid = 1; end
      end
      repeat (3) tick();
      ia_sending_done = 1; w_sending_done = 1; tick();
      ia_sending_done = 0; w_sending_done = 0;
    end
    chk("t2_done", done, 1);
    chk("t2_step", step_count, 3);
    chk("t2_busy", busy, 0);
    chk("t2_trig_cnt", n_ia_trig - s_trig, 3);
    chk("t2_done_cnt", n_done - s_done, 1);
    chk("t2_two_owners", n_both - s_both, 0);
    ia_load_req = 0; w_load_req = 0;

    // Split sending_done, plus a stray done seen while waiting.
    ia_data_valid = 1; w_data_valid = 1;
    s_trig = n_ia_trig;
    start = 1; total_steps = 1; tick();            // c1
    start = 0;
    chk("t3_trig_early", ia_send_trigger, 0);
    ia_sending_done = 1; w_sending_done = 1; tick(); // c2
    ia_sending_done = 0; w_sending_done = 0;
    chk("t3_trig", ia_send_trigger, 1);
    repeat (10) tick();                            // c12
    ia_sending_done = 1; tick();                   // c13
    ia_sending_done = 0; repeat (3) tick();        // c16
    chk("t3_step_hold", step_count, 0);
    chk("t3_done_hold", done, 0);
    chk("t3_one_trig", n_ia_trig - s_trig, 1);
    w_sending_done = 1; tick();                    // c17
    w_sending_done = 0;
    chk("t3_step", step_count, 1);
    chk("t3_done", done, 1);

    // Empty layer: done only, no grants or triggers even with inputs active.
    ia_load_req = 1; w_load_req = 1;
    s_trig = n_ia_trig; s_done = n_done; s_igt = n_ia_gnt; s_wgt = n_w_gnt;
    start = 1; total_steps = 0; tick();            // c1
    start = 0;
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 1);
    tick();
    chk("t4_done_pulse", done, 0);
    chk("t4_busy_fall", busy, 0);
    repeat (3) tick();
    chk("t4_no_ia_gnt", n_ia_gnt - s_igt, 0);
    chk("t4_no_w_gnt", n_w_gnt - s_wgt, 0);
    chk("t4_no_trig", n_ia_trig - s_trig, 0);
    chk("t4_done_cnt", n_done - s_done, 1);
    ia_load_req = 0; w_load_req = 0; ia_data_valid = 0; w_data_valid = 0;

    // Reuse run: IA loaded once, weights reloaded every step.
    s_trig = n_ia_trig; s_done = n_done;
    start = 1; total_steps = 4; tick();
    start = 0;
    ia_load_req = 1;
    wait_gnt(g);
    chk("t5_ia_gnt", g, 0);
    ia_load_req = 0; ia_data_valid = 1;
    for (int k = 1; k <= 4; k++) begin
      w_load_req = 1; w_data_valid = 0;
      wait_gnt(g);
      chk($sformatf("t5_w_gnt%0d", k), g, 1);
      w_load_req = 0; w_data_valid = 1;
      wait_trig(ok);
      chk($sformatf("t5_trig%0d", k), ok, 1);
      chk($sformatf("t5_wtrig%0d", k), w_send_trigger, 1);
      repeat (2) tick();
      ia_sending_done = 1; w_sending_done = 1; tick();
      ia_sending_done = 0; w_sending_done = 0;
      chk($sformatf("t5_step%0d", k), step_count, k);
      chk($sformatf("t5_busy%0d", k), busy, (k < 4));
      chk($sformatf("t5_done%0d", k), done, (k == 4));
    end
    chk("t5_trig_cnt", n_ia_trig - s_trig, 4);
    chk("t5_done_cnt", n_done - s_done, 1);
    ia_data_valid = 0; w_data_valid = 0;

    // Mid-run reset during step 2's trigger cycle, then a clean rerun.
    ia_data_valid = 1; w_data_valid = 1;
    start = 1; total_steps = 3; tick();            // c1
    start = 0; tick();                             // c2
    chk("t6_trig1", ia_send_trigger, 1);
    repeat (2) tick();                             // c4
    ia_sending_done = 1; w_sending_done = 1; tick(); // c5
    ia_sending_done = 0; w_sending_done = 0;
    chk("t6_step1", step_count, 1);
    chk("t6_trig_gap", ia_send_trigger, 0);
    tick();                                        // c6
    chk("t6_nobubble", ia_send_trigger, 1);
    rst_n = 1'b0; #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_step", step_count, 0);
    chk("t6_rst_ia_trig", ia_send_trigger, 0);
    chk("t6_rst_w_trig", w_send_trigger, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_gnt", {ia_load_granted, w_load_granted}, 0);
    repeat (2) tick();
    rst_n = 1'b1; tick();
    start = 1; total_steps = 1; tick();            // c1
    start = 0; tick();                             // c2
    chk("t6_re_trig", ia_send_trigger, 1);
    ia_sending_done = 1; w_sending_done = 1; tick(); // c3
    ia_sending_done = 0; w_sending_done = 0;
    chk("t6_re_done", done, 1);
    chk("t6_re_step", step_count, 1);
    chk("t6_re_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
